// File: rtl/repeated_sub_divider.sv
// Unsigned divider by repeated subtraction: IDLE -> SUB (one subtraction per cycle) -> FIN.
// Define DIV_ZERO_FLAG_EN to add DIV_BY_ZERO and accept B=0 as an error case instead of ignoring it.
module repeated_sub_divider #(
  parameter int unsigned DIVIDEND_W = 6,
  parameter int unsigned DIVISOR_W  = 3
) (
  input  logic                  SYS_CLOCK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic [DIVIDEND_W-1:0] A,
  input  logic [DIVISOR_W-1:0]  B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DIVIDEND_W-1:0] QUOTIENT,
`ifdef DIV_ZERO_FLAG_EN
  output logic [DIVISOR_W-1:0]  REMAINDER,
  output logic                  DIV_BY_ZERO
`else
  output logic [DIVISOR_W-1:0]  REMAINDER
`endif
);

  typedef enum logic [1:0] {StIdle, StSub, StFin} state_e;

  state_e                state_q;
  logic [DIVIDEND_W-1:0] r_acc_q;
  logic [DIVIDEND_W-1:0] q_acc_q;
  logic [DIVISOR_W-1:0]  b_reg_q;
  logic [DIVIDEND_W-1:0] b_ext;
  logic                  start_ok;

  assign b_ext = DIVIDEND_W'(b_reg_q);

`ifdef DIV_ZERO_FLAG_EN
  assign start_ok = START;
`else
  // A zero divisor would never leave SUB, so such a request is simply not accepted.
  assign start_ok = START && (B != '0);
`endif

  always_ff @(posedge SYS_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      r_acc_q     <= '0;
      q_acc_q     <= '0;
      b_reg_q     <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      QUOTIENT    <= '0;
      REMAINDER   <= '0;
`ifdef DIV_ZERO_FLAG_EN
      DIV_BY_ZERO <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            r_acc_q     <= A;
            b_reg_q     <= B;
            q_acc_q     <= '0;
            BUSY        <= 1'b1;
            state_q     <= StSub;
`ifdef DIV_ZERO_FLAG_EN
            DIV_BY_ZERO <= 1'b0;
`endif
          end
        end
        StSub: begin
`ifdef DIV_ZERO_FLAG_EN
          if (b_reg_q == '0) begin
            QUOTIENT    <= '1;
            REMAINDER   <= '0;
            DIV_BY_ZERO <= 1'b1;
            BUSY        <= 1'b0;
            DONE        <= 1'b1;
            state_q     <= StFin;
          end else
`endif
          if (r_acc_q >= b_ext) begin
            // Quotient is bounded by A, so q_acc_q cannot wrap.
            r_acc_q <= r_acc_q - b_ext;
            q_acc_q <= q_acc_q + DIVIDEND_W'(1);
          end else begin
            QUOTIENT  <= q_acc_q;
            REMAINDER <= r_acc_q[DIVISOR_W-1:0];
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
            state_q   <= StFin;
          end
        end
        StFin: begin
          DONE    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_repeated_sub_divider.sv
// Self-checking bench for repeated_sub_divider against plain integer division.
module tb_repeated_sub_divider;

  localparam int unsigned DW = 6;
  localparam int unsigned BW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] a = '0;
  logic [BW-1:0] b = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [BW-1:0] remainder;
  logic          div_by_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  repeated_sub_divider #(
    .DIVIDEND_W (DW),
    .DIVISOR_W  (BW)
  ) dut (
    .SYS_CLOCK   (clk),
    .RESET_N     (rst_n),
    .START       (start),
    .A           (a),
    .B           (b),
    .BUSY        (busy),
    .DONE        (done),
    .QUOTIENT    (quotient),
`ifdef DIV_ZERO_FLAG_EN
    .REMAINDER   (remainder),
    .DIV_BY_ZERO (div_by_zero)
`else
    .REMAINDER   (remainder)
`endif
  );

`ifndef DIV_ZERO_FLAG_EN
  assign div_by_zero = 1'b0;
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      failures++;
      $display("FAIL reset_async: got busy=%0d done=%0d q=%0d r=%0d dz=%0d, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder} !== '0) begin
      failures++;
      $display("FAIL reset_held: got busy=%0d done=%0d q=%0d r=%0d, required all 0",
               busy, done, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One operation: checks DONE edge count, pulse count, BUSY length and result.
  task automatic run_op(input int av, input int bv, input bit scramble, input string name);
    int exp_q, exp_r, done_edge, done_cnt, busy_cnt;
    exp_q = av / bv;
    exp_r = av % bv;
    done_edge = -1;
    done_cnt = 0;
    busy_cnt = 0;
    @(negedge clk);
    a = DW'(av);
    b = BW'(bv);
    start = 1'b1;
    for (int k = 1; k <= exp_q + 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        start = 1'b0;
        if (scramble) begin
          a = '0;
          b = '0;
        end
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_edge = k;
      end
    end
    checks++;
    if (done_cnt != 1 || done_edge != exp_q + 2) begin
      failures++;
      $display("FAIL %s_done: got %0d pulses at edge %0d, required 1 pulse at edge %0d",
               name, done_cnt, done_edge, exp_q + 2);
    end
    checks++;
    if (busy_cnt != exp_q + 1) begin
      failures++;
      $display("FAIL %s_busy: got %0d busy cycles, required %0d", name, busy_cnt, exp_q + 1);
    end
    checks++;
    if (int'(quotient) != exp_q || int'(remainder) != exp_r) begin
      failures++;
      $display("FAIL %s_result: got q=%0d r=%0d, required q=%0d r=%0d",
               name, quotient, remainder, exp_q, exp_r);
    end
  endtask

  task automatic test_directed();
    run_op(13, 3, 1'b0, "op_13_3");
    run_op(2, 5, 1'b0, "op_2_5");
    run_op(63, 1, 1'b1, "op_63_1_scrambled");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (quotient !== 6'd63 || remainder !== 3'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: got q=%0d r=%0d done=%0d, required q=63 r=0 done=0",
               quotient, remainder, done);
    end
  endtask

  // START held high: one op per 9 edges, DONE only on the 8th edge of each.
  task automatic test_back_to_back();
    int pulses, idx;
    bit exp_done, exp_busy;
    pulses = 0;
    @(negedge clk);
    a = 6'd36;
    b = 3'd6;
    start = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      @(posedge clk);
      #1;
      idx = (k - 1) % 9;
      exp_done = (idx == 7);
      exp_busy = (idx <= 6);
      if (done === 1'b1) pulses++;
      checks++;
      if (done !== exp_done || busy !== exp_busy) begin
        failures++;
        $display("FAIL b2b_edge%0d: got done=%0d busy=%0d, required done=%0d busy=%0d",
                 k, done, busy, exp_done, exp_busy);
      end
    end
    start = 1'b0;
    checks++;
    if (pulses != 3 || quotient !== 6'd6 || remainder !== 3'd0) begin
      failures++;
      $display("FAIL b2b_result: got pulses=%0d q=%0d r=%0d, required pulses=3 q=6 r=0",
               pulses, quotient, remainder);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_op(int'($urandom_range(0, 63)), int'($urandom_range(1, 7)),
             bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_div_zero();
    int done_cnt, busy_cnt, done_edge;
    logic [DW-1:0] q0;
    logic [BW-1:0] r0;
    q0 = quotient;
    r0 = remainder;
    done_cnt = 0;
    busy_cnt = 0;
    done_edge = -1;
    @(negedge clk);
    a = 6'd9;
    b = 3'd0;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_edge = k;
      end
    end
`ifdef DIV_ZERO_FLAG_EN
    q0 = q0;
    r0 = r0;
    checks++;
    if (done_cnt != 1 || done_edge != 2 || busy_cnt != 1) begin
      failures++;
      $display("FAIL dz_timing: got %0d pulses at edge %0d busy=%0d, required 1 at edge 2 busy=1",
               done_cnt, done_edge, busy_cnt);
    end
    checks++;
    if (quotient !== 6'd63 || remainder !== 3'd0 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dz_result: got q=%0d r=%0d dz=%0d, required q=63 r=0 dz=1",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    a = 6'd10;
    b = 3'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL dz_clear: got dz=%0d, required 0", div_by_zero);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (quotient !== 6'd3 || remainder !== 3'd1) begin
      failures++;
      $display("FAIL dz_next_op: got q=%0d r=%0d, required q=3 r=1", quotient, remainder);
    end
`else
    checks++;
    if (done_cnt != 0 || busy_cnt != 0) begin
      failures++;
      $display("FAIL dz_ignored: got %0d done pulses %0d busy cycles, required 0 and 0",
               done_cnt, busy_cnt);
    end
    checks++;
    if (quotient !== q0 || remainder !== r0) begin
      failures++;
      $display("FAIL dz_outputs: got q=%0d r=%0d, required q=%0d r=%0d",
               quotient, remainder, q0, r0);
    end
`endif
  endtask

  task automatic test_mid_reset();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    a = 6'd50;
    b = 3'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      failures++;
      $display("FAIL mid_reset: got busy=%0d done=%0d q=%0d r=%0d dz=%0d, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL mid_reset_abort: got %0d active cycles after reset, required 0", done_cnt);
    end
    run_op(50, 7, 1'b0, "post_reset_50_7");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_div_zero();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
